// File: rtl/bus_gate_keeper.sv
// bus_gate_keeper
//   Shared datapath bus for CHANNELS gated sources. Sources are muxed onto
//   the bus (no internal tri-states); the lowest-index asserted gate wins.
//   When no gate is asserted, a keeper register drives the last resolved
//   value so the bus never floats. Multi-gate cycles are flagged as
//   contention and recorded in sticky status.
//
//   Optional feature macro: BUS_GATE_KEEPER_CNT_EN
//     defined   -> saturating contention event counter is built
//     undefined -> no counter register, contention_cnt tied to 0
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   data_in        flattened sources, channel i at [i*WIDTH +: WIDTH]
//   gate           per-channel drive enable
//   clr_err        synchronous clear of err_sticky / contention_cnt
//   bus_out        resolved bus value (combinational)
//   bus_valid      at least one gate asserted (combinational)
//   owner          index of the driving channel (combinational)
//   contention     two or more gates asserted (combinational)
//   err_sticky     registered, set by any contention cycle
//   contention_cnt registered saturating contention cycle count
//   last_owner     registered index of most recent driving channel

module bus_gate_keeper #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  parameter int OWN_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       gate,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      bus_valid,
  output logic [OWN_W-1:0]          owner,
  output logic                      contention,
  output logic                      err_sticky,
  output logic [CNT_WIDTH-1:0]      contention_cnt,
  output logic [OWN_W-1:0]          last_owner
);

  generate
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
      $error("bus_gate_keeper: CHANNELS must be within 2..16");
    end
  endgenerate

  logic [WIDTH-1:0] keep_q, keep_d;
  logic [OWN_W-1:0] last_owner_q, last_owner_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sel_data;
  logic [OWN_W-1:0] sel_idx;
  logic             any_gate;

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (gate[i]) begin
        sel_data = data_in[i*WIDTH +: WIDTH];
        sel_idx  = OWN_W'(i);
      end
    end
  end

  assign any_gate = |gate;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign contention = |(gate & (gate - CHANNELS'(1)));

  assign bus_valid = any_gate;
  assign bus_out   = any_gate ? sel_data : keep_q;
  assign owner     = any_gate ? sel_idx  : last_owner_q;

  always_comb begin
    keep_d       = keep_q;
    last_owner_d = last_owner_q;
    err_d        = err_q;
    if (any_gate) begin
      keep_d       = sel_data;
      last_owner_d = sel_idx;
    end
    // Set beats clear so a contention in the clearing cycle is not lost.
    if (contention) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keep_q       <= '0;
      last_owner_q <= '0;
      err_q        <= 1'b0;
    end else begin
      keep_q       <= keep_d;
      last_owner_q <= last_owner_d;
      err_q        <= err_d;
    end
  end

  assign err_sticky = err_q;
  assign last_owner = last_owner_q;

`ifdef BUS_GATE_KEEPER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err && contention) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (clr_err) begin
      cnt_d = '0;
    end else if (contention && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign contention_cnt = cnt_q;
`else
  assign contention_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_gate_keeper.sv
// Testbench for bus_gate_keeper: directed scenarios followed by random
// traffic, all checked against a behavioural model of the bus rules.
// A narrow counter (CNT_WIDTH=2) is used so saturation is reachable.

module tb_bus_gate_keeper;

  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 4;
  localparam int CNT_WIDTH = 2;
  localparam int OWN_W     = 2;
  localparam int CNT_MAX   = 3;

`ifdef BUS_GATE_KEEPER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       gate;
  logic                      clr_err;
  logic [WIDTH-1:0]          bus_out;
  logic                      bus_valid;
  logic [OWN_W-1:0]          owner;
  logic                      contention;
  logic                      err_sticky;
  logic [CNT_WIDTH-1:0]      contention_cnt;
  logic [OWN_W-1:0]          last_owner;

  bus_gate_keeper #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .gate(gate),
    .clr_err(clr_err), .bus_out(bus_out), .bus_valid(bus_valid),
    .owner(owner), .contention(contention), .err_sticky(err_sticky),
    .contention_cnt(contention_cnt), .last_owner(last_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state
  int m_keep, m_last, m_cnt;
  bit m_err;
  logic [WIDTH-1:0] ch [CHANNELS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic cycle(input logic [CHANNELS-1:0] g, input bit clr, input bit rst);
    int win, n;
    int e_bus, e_own;
    bit e_valid, e_cont;
    for (int i = 0; i < CHANNELS; i++) data_in[i*WIDTH +: WIDTH] = ch[i];
    gate    = g;
    clr_err = clr;
    reset   = rst;
    win = -1;
    n   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (g[i]) begin
        n++;
        if (win < 0) win = i;
      end
    end
    e_valid = (win >= 0);
    e_cont  = (n >= 2);
    e_bus   = e_valid ? int'(ch[win]) : m_keep;
    e_own   = e_valid ? win : m_last;
    #1;
    chk("bus_out",    32'(bus_out),    32'(e_bus));
    chk("bus_valid",  32'(bus_valid),  32'(e_valid));
    chk("owner",      32'(owner),      32'(e_own));
    chk("contention", 32'(contention), 32'(e_cont));
    @(posedge clk);
    if (rst) begin
      m_keep = 0; m_last = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (e_valid) begin
        m_keep = e_bus;
        m_last = e_own;
      end
      if (e_cont) m_err = 1;
      else if (clr) m_err = 0;
      if (clr) m_cnt = e_cont ? 1 : 0;
      else if (e_cont && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    #1;
    chk("err_sticky",     32'(err_sticky),     32'(m_err));
    chk("contention_cnt", 32'(contention_cnt), CNT_ON ? 32'(m_cnt) : 32'd0);
    chk("last_owner",     32'(last_owner),     32'(m_last));
  endtask

  initial begin
    for (int i = 0; i < CHANNELS; i++) ch[i] = 16'h0;
    data_in = '0;
    gate    = '0;
    clr_err = 1'b0;
    reset   = 1'b1;

    // Reset for two cycles with no gate asserted
    repeat (2) @(posedge clk);
    #1;
    m_keep = 0; m_last = 0; m_err = 0; m_cnt = 0;
    chk("rst_bus_out",   32'(bus_out),        32'h0);
    chk("rst_bus_valid", 32'(bus_valid),      32'h0);
    chk("rst_err",       32'(err_sticky),     32'h0);
    chk("rst_cnt",       32'(contention_cnt), 32'h0);
    chk("rst_last",      32'(last_owner),     32'h0);

    // Single driver, then keeper holds
    ch[2] = 16'hBEEF;
    cycle(4'b0100, 1'b0, 1'b0);
    ch[2] = 16'h0;
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("keeper_bus", 32'(bus_out), 32'hBEEF);

    // Contention priority for three cycles
    ch[1] = 16'h1234;
    ch[3] = 16'hFFFF;
    repeat (3) cycle(4'b1010, 1'b0, 1'b0);
    chk("prio_cnt", 32'(contention_cnt), CNT_ON ? 32'd3 : 32'd0);

    // Set wins over clear, then clear takes effect
    cycle(4'b1010, 1'b1, 1'b0);
    chk("clr_vs_set_err", 32'(err_sticky), 32'd1);
    ch[0] = 16'h0A0A;
    cycle(4'b0001, 1'b1, 1'b0);
    chk("clr_err_done", 32'(err_sticky), 32'd0);

    // Saturation: six contention cycles
    ch[2] = 16'h5555;
    ch[3] = 16'hAAAA;
    repeat (6) cycle(4'b1100, 1'b0, 1'b0);

    // Mid-operation reset during contention
    ch[0] = 16'hC0DE;
    ch[1] = 16'h1111;
    ch[2] = 16'hBEEF;
    cycle(4'b0100, 1'b0, 1'b0);
    chk("mid_keep_pre", 32'(bus_out), 32'hBEEF);
    cycle(4'b0011, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("mid_keep_post", 32'(bus_out), 32'h0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      logic [CHANNELS-1:0] g;
      for (int i = 0; i < CHANNELS; i++) ch[i] = 16'($urandom);
      g = ($urandom_range(0, 3) == 0) ? '0 : CHANNELS'($urandom);
      cycle(g, ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
